// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver, LSB first, 16x oversampling with a
// three-sample majority vote around the middle of every bit.
// Delivers accepted bytes to the RX FIFO push side as a one-cycle strobe and
// flags false starts (silently), framing errors and FIFO overruns.
module uart_rx_os16 #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_full,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun_err
);

   // Clocks per oversampling tick; the bit timing assumes 16 ticks per bit.
   localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic             rx_meta;
   logic             rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [2:0]       state;
   logic [3:0]       scnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             samp7;
   logic             samp8;
   logic             vote;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Free-running tick divider, deliberately not resynchronised to frames.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   // Capture the first two mid-bit samples; the third is rx_s on the scnt=9 tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp7 <= 1'b1;
         samp8 <= 1'b1;
      end else if (tick) begin
         if (scnt == 4'd7) samp7 <= rx_s;
         if (scnt == 4'd8) samp8 <= rx_s;
      end
   end

   assign vote = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

   // Frame state machine, shift register and one-cycle result strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         scnt        <= 4'd0;
         bit_idx     <= 3'd0;
         shift       <= 8'h00;
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         if (tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state <= ST_START;
                     scnt  <= 4'd0;
                  end
               end
               ST_START: begin
                  scnt <= scnt + 4'd1;
                  if (scnt == 4'd9 && vote) begin
                     state <= ST_IDLE;
                     scnt  <= 4'd0;
                  end else if (scnt == 4'd15) begin
                     state   <= ST_DATA;
                     scnt    <= 4'd0;
                     bit_idx <= 3'd0;
                  end
               end
               ST_DATA: begin
                  scnt <= scnt + 4'd1;
                  if (scnt == 4'd9) begin
                     shift <= {vote, shift[7:1]};
                  end
                  if (scnt == 4'd15) begin
                     if (bit_idx == 3'd7) begin
                        state <= ST_STOP;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end
               end
               ST_STOP: begin
                  scnt <= scnt + 4'd1;
                  if (scnt == 4'd9) begin
                     scnt <= 4'd0;
                     if (!vote) begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                     end else if (rx_full) begin
                        overrun_err <= 1'b1;
                        state       <= ST_IDLE;
                     end else begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        state    <= ST_IDLE;
                     end
                  end
               end
               ST_BREAK: begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  scnt  <= 4'd0;
               end
            endcase
         end
      end
   end

   assign rx_busy = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed and randomised frames against a byte-level model
// of what the receiver should deliver. Runs the DUT at a fast baud rate so a
// bit is 64 clocks (DIV=4) and the whole sequence stays short.
module tb_uart_rx_os16;

   localparam int CLK_FREQ = 100_000_000;
   localparam int BAUD     = 1_562_500;
   localparam int BIT      = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rx_full = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun_err;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         got_fe = 0;
   int         got_ovr = 0;
   int         multi = 0;
   int         exp_fe = 0;
   int         exp_ovr = 0;
   logic [7:0] exp_last = 8'h00;

   uart_rx_os16 #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_full    (rx_full),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .overrun_err(overrun_err)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Record every output event on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (frame_err) got_fe++;
      if (overrun_err) got_ovr++;
      if ((int'(rx_valid) + int'(frame_err) + int'(overrun_err)) > 1) multi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
   endtask

   // One serial frame; optional high spike of spike_w clocks centred on data bit spike_bit.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input int spike_bit, input int spike_w);
      int pre;
      if (!stop_bit) begin
         exp_fe++;
      end else if (rx_full) begin
         exp_ovr++;
      end else begin
         exp_q.push_back(d);
         exp_last = d;
      end
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) begin
         if (i == spike_bit) begin
            pre = BIT / 2 - spike_w / 2;
            drive(d[i], pre);
            drive(1'b1, spike_w);
            drive(d[i], BIT - pre - spike_w);
         end else begin
            drive(d[i], BIT);
         end
      end
      drive(stop_bit, BIT);
   endtask

   task automatic check_progress(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      end
      check({tag, "_frame_err"}, got_fe, exp_fe);
      check({tag, "_overrun"}, got_ovr, exp_ovr);
      check({tag, "_rx_data"}, rx_data, exp_last);
      check({tag, "_busy_idle"}, rx_busy, 1'b0);
   endtask

   initial begin
      logic [7:0] b2b[4];
      logic [7:0] d;
      logic [7:0] partial;
      int gap;
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'hAA;
      partial = 8'h77;

      // Reset values.
      repeat (3) @(negedge clk);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_busy", rx_busy, 1'b0);
      check("reset_errs", {frame_err, overrun_err}, 2'b00);
      rst = 1'b1;
      drive(1'b1, 2 * BIT);

      // Single byte, then held across idle time.
      send_frame(8'h31, 1'b1, -1, 0);
      check_progress("byte31");
      drive(1'b1, 2 * BIT);
      check("hold31", rx_data, 8'h31);

      // Back-to-back frames with no idle gap.
      for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, -1, 0);
      check_progress("b2b");
      drive(1'b1, BIT);

      // Short low glitch on an idle line is a false start.
      drive(1'b0, 12);
      check("glitch_busy", rx_busy, 1'b1);
      drive(1'b0, 6);
      drive(1'b1, 3 * BIT);
      check_progress("glitch");

      // Spikes mid-bit are voted away.
      send_frame(8'h3C, 1'b1, 2, 6);
      check_progress("spike_b2");
      drive(1'b1, BIT);
      send_frame(8'h3C, 1'b1, 1, 3);
      check_progress("spike_b1");
      drive(1'b1, BIT);

      // Bad stop bit followed by a held-low line, then a good frame.
      send_frame(8'h5A, 1'b0, -1, 0);
      drive(1'b0, BIT + BIT / 2);
      check("break_busy", rx_busy, 1'b0);
      drive(1'b0, BIT + BIT / 2);
      drive(1'b1, 2 * BIT);
      check_progress("framing");
      send_frame(8'hA5, 1'b1, -1, 0);
      check_progress("after_break");
      drive(1'b1, BIT);

      // FIFO full drops a good byte.
      rx_full = 1'b1;
      send_frame(8'h12, 1'b1, -1, 0);
      rx_full = 1'b0;
      check_progress("overrun");
      drive(1'b1, BIT);
      send_frame(8'h34, 1'b1, -1, 0);
      check_progress("after_overrun");
      drive(1'b1, BIT);

      // Asynchronous reset in the middle of a frame.
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(partial[i], BIT);
      check("midframe_busy", rx_busy, 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 12'h000);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check("held_rst_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 12'h000);
      rst = 1'b1;
      exp_last = 8'h00;
      drive(1'b1, 2 * BIT);
      send_frame(8'h41, 1'b1, -1, 0);
      check_progress("after_reset");

      // Random bytes, random idle gaps and phases, occasional full FIFO.
      for (int n = 0; n < 12; n++) begin
         d = 8'($urandom);
         rx_full = ($urandom_range(0, 3) == 0);
         send_frame(d, 1'b1, -1, 0);
         check_progress($sformatf("rand%0d", n));
         gap = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 2) * BIT + $urandom_range(1, 13));
         if (gap > 0) drive(1'b1, gap);
      end
      rx_full = 1'b0;
      drive(1'b1, BIT);
      check_progress("final");
      check("one_event_per_cycle", multi, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver, 8N1, LSB first, 16x oversampled with 3-sample majority vote per bit.
- Sits between the synchronised `uart_rx` pin and the RX FIFO push side in `uart_top`.
- It is the receiving end of the frames the loopback bench drives: idle-high line, start 0, 8 data bits, stop 1.
- Flags false starts, framing errors and FIFO overrun.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit, fixed at 16.
- DIV: localparam, CLK_FREQ/(BAUD*OVERSAMPLE) truncated, = 651. One bit = 10416 clk = 104160 ns.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- rx  input  1  raw serial line, asynchronous to clk.
- rx_full  input  1  FIFO full; sampled when a byte completes.
- rx_data  output  8  last accepted byte; holds until the next accepted byte.
- rx_valid  output  1  one-cycle push strobe; rx_data is valid in the same cycle.
- rx_busy  output  1  high in START, DATA and STOP.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- overrun_err  output  1  one-cycle pulse when a good byte is dropped because rx_full=1.

Behaviour:
- Reset values:
  - rx_data=0x00; rx_valid, rx_busy, frame_err, overrun_err all 0.
  - State IDLE; both synchroniser flops=1; tick and sample counters=0; shift register=0.
- Synchroniser: 2-FF on rx. All decisions use the second flop (rx_s).
- Tick generator:
  - Free-running counter 0..DIV-1.
  - tick=1 for one clk when the counter equals DIV-1. Not restarted by frame activity.
- Sample counter scnt: 4 bits, cleared on state entry, incremented on each tick.
  - Samples captured at scnt=7, 8 and 9.
  - Bit value = majority of the three, decided on the tick where scnt=9.
- IDLE:
  - On a tick with rx_s=0: go to START, scnt=0.
  - Otherwise stay.
- START:
  - At decision, majority 1 = false start: return to IDLE, no outputs.
  - Majority 0: wait to scnt=15, then on the next tick go to DATA with scnt=0 and bit index=0.
- DATA:
  - At each decision, shift the bit in LSB-first (bit i lands in data[i]).
  - After scnt=15 wraps: increment the bit index.
  - After bit 7 completes: go to STOP.
- STOP, decided at scnt=9 (no wait for the end of the bit):
  - Majority 1 and rx_full=0: rx_data<=shift, rx_valid=1 for one cycle, go to IDLE.
  - Majority 1 and rx_full=1: overrun_err=1 for one cycle, rx_data unchanged, no rx_valid, go to IDLE.
  - Majority 0: frame_err=1 for one cycle, no rx_valid, rx_data unchanged, go to BREAK.
- BREAK: stay until a tick with rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: rx_valid asserts 1 clk after the STOP decision tick. That is about 9.56 bit periods after the start edge, plus 2-3 clk of synchroniser and tick quantisation.
- Frame spacing: back-to-back frames with zero idle between the stop bit and the next start must each be received, because STOP exits at mid-bit.
- Exactly one of rx_valid, frame_err or overrun_err fires per completed frame. None fires on a false start.
- rx_busy is 0 in IDLE and BREAK.
- Async reset mid-frame: all outputs return to reset values immediately and any partial byte is discarded. After release, the first full frame is received normally.

Test Plan:
- Send 0x31 at 9600 baud (104160 ns/bit), rx_full=0 -> one rx_valid pulse, rx_data=0x31, 0x31 held until the next byte, no error pulses.
- Send 0x00, 0xFF, 0x55, 0xAA back-to-back with no idle gap -> four rx_valid pulses, data in order, no frame_err.
- Drive a 30 µs low glitch on an idle line -> no rx_valid or errors, state back in IDLE. Separately, send 0x3C with a 10 µs high spike centred mid-bit on bit 2 -> rx_data=0x3C (majority rejects the spike).
- Send 0x5A with stop bit=0, hold rx low 3 bit times, release, then send 0xA5 -> exactly one frame_err, no valid for 0x5A, then rx_valid with 0xA5.
- Send 0x12 with rx_full=1 -> one overrun_err, no rx_valid, rx_data keeps its prior value. Then send 0x34 with rx_full=0 -> rx_valid, rx_data=0x34.
- Pulse rst=0 after 4 data bits of 0x77, release, send 0x41 -> all outputs 0 during reset, no valid for the partial byte, then rx_valid with rx_data=0x41.
